instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the main decoder. Owns the program counter and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents one instruction at a time, together with its opcode field and PC, to the decode stage.
- Computes the next PC from the decode/datapath branch decision when the instruction is accepted.
- Detects fetch timeouts and misaligned targets, and parks in a sticky error state when either occurs.

Parameters:
- RESET_PC, 32'h0000_0000: PC of the first fetch after reset; must be word-aligned.
- TIMEOUT, 16: maximum FETCH cycles without imem_ack before an error; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the fetch; equals pc while imem_req=1.
- imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- instr_valid  output  1  instr, opcode and instr_pc are valid for decode.
- instr  output  32  held instruction word.
- opcode  output  7  instr[6:0], combinational from instr; feeds the decoder opcode input.
- instr_pc  output  32  PC of the held instruction.
- dec_ready  input  1  decode/execute accepts the held instruction this cycle.
- branch  input  1  decoder branch control for the held instruction.
- zero  input  1  ALU zero flag for the held instruction.
- branch_imm  input  32  sign-extended byte offset for the branch target.
- fetch_err  output  1  sticky error flag.
- err_addr  output  32  offending address (fetch address or branch target).

Behaviour:
- Interface: single clock clk; synchronous active-high reset rst, which overrides every other input in the cycle it is sampled.
- Reset values:
  - pc = RESET_PC; state = IDLE; imem_req = 0; imem_addr = RESET_PC.
  - instr_valid = 0; instr = 32'h0000_0013 (NOP), so opcode = 7'b0010011; instr_pc = 0.
  - fetch_err = 0; err_addr = 0; timeout counter = 0.
- All outputs except opcode are registered.
- States:
  - IDLE: the cycle after rst deasserts, go to FETCH.
  - FETCH: imem_req = 1, imem_addr = pc; the counter increments each cycle without ack.
    - imem_ack=1 in any FETCH cycle, including the first: next cycle latch instr = imem_rdata, instr_pc = pc, instr_valid = 1, imem_req = 0, counter = 0, state = HOLD.
    - Counter reaches TIMEOUT-1 with no ack: next cycle go to ERROR, err_addr = pc.
  - HOLD: instr_valid = 1; instr, instr_pc and opcode are held stable until accept.
    - Accept = instr_valid & dec_ready. branch and zero are sampled only in the accept cycle.
    - Target = (branch & zero) ? instr_pc + branch_imm : instr_pc + 4, using modulo-2^32 wrap (32'hFFFF_FFFC + 4 = 0).
    - Target[1:0] != 0: next cycle go to ERROR, err_addr = target.
    - Otherwise: next cycle pc = target, instr_valid = 0, state = FETCH.
  - ERROR: fetch_err = 1, imem_req = 0, instr_valid = 0; remains until rst.
- Latency: ack in cycle t gives instr_valid in cycle t+1. Accept in cycle u gives imem_req=1 with the new address in cycle u+1. Peak throughput is one instruction per 2 cycles.
- Boundary rules:
  - imem_ack outside FETCH is ignored, with no state change.
  - dec_ready while instr_valid=0 is ignored.
  - rst asserted mid-FETCH: an ack in that same cycle is discarded; the next valid fetch is from RESET_PC.
  - In FETCH, ack and timeout in the same cycle: the ack wins.
  - branch=1 with zero=0 gives sequential PC. branch_imm = 0 with branch taken re-fetches the same PC.

Test Plan:
- rst for 2 cycles, then release, memory acks after 1 wait cycle with 32'h0000_0093 -> imem_addr=0, instr_valid=1 with instr=32'h0000_0093, opcode=7'h13, instr_pc=0.
- Accept with branch=0 -> next imem_addr=4. Accept again -> imem_addr=8. Check instr_valid low for exactly one cycle after each accept.
- instr_pc=8, branch=1, zero=1, branch_imm=32'hFFFF_FFF8 -> next fetch at 0. Same with zero=0 -> next fetch at 12.
- Hold dec_ready=0 for 5 cycles while imem_ack pulses spuriously -> instr and instr_pc unchanged, imem_req=0.
- Withhold imem_ack for TIMEOUT=16 cycles at pc=12 -> fetch_err=1, err_addr=12, imem_req=0 held. rst clears it, and the next fetch is from RESET_PC.
- Taken branch with branch_imm=6 from instr_pc=4 -> fetch_err=1, err_addr=10. Separately, assert rst in the same cycle as imem_ack -> instr_valid stays 0 and the next fetch is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake,
// holds one instruction for decode, and resolves the next PC on accept.
// Fetch timeouts and misaligned targets park the unit in a sticky error state.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [6:0]  o_opcode,
   output logic [31:0] o_instr_pc,
   input  logic        i_dec_ready,
   input  logic        i_branch,
   input  logic        i_zero,
   input  logic [31:0] i_branch_imm,
   output logic        o_fetch_err,
   output logic [31:0] o_err_addr
);

   localparam int unsigned CNT_W   = 8;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_ERROR = 2'd3;

   logic [1:0]       r_state;
   logic [31:0]      r_pc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_imem_req;
   logic             r_instr_valid;
   logic [31:0]      r_instr;
   logic [31:0]      r_instr_pc;
   logic             r_fetch_err;
   logic [31:0]      r_err_addr;

   logic [1:0]       w_state_nxt;
   logic [31:0]      w_pc_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_imem_req_nxt;
   logic             w_instr_valid_nxt;
   logic [31:0]      w_instr_nxt;
   logic [31:0]      w_instr_pc_nxt;
   logic             w_fetch_err_nxt;
   logic [31:0]      w_err_addr_nxt;

   logic             w_accept;
   logic [31:0]      w_target;

   // Branch resolution for the held instruction (modulo-2^32 arithmetic)
   assign w_accept = r_instr_valid & i_dec_ready;
   assign w_target = (i_branch & i_zero) ? (r_instr_pc + i_branch_imm)
                                         : (r_instr_pc + 32'd4);

   // State register and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_cnt         <= '0;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
         r_instr       <= NOP;
         r_instr_pc    <= 32'h0;
         r_fetch_err   <= 1'b0;
         r_err_addr    <= 32'h0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_cnt         <= w_cnt_nxt;
         r_imem_req    <= w_imem_req_nxt;
         r_instr_valid <= w_instr_valid_nxt;
         r_instr       <= w_instr_nxt;
         r_instr_pc    <= w_instr_pc_nxt;
         r_fetch_err   <= w_fetch_err_nxt;
         r_err_addr    <= w_err_addr_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_cnt_nxt         = r_cnt;
      w_imem_req_nxt    = r_imem_req;
      w_instr_valid_nxt = r_instr_valid;
      w_instr_nxt       = r_instr;
      w_instr_pc_nxt    = r_instr_pc;
      w_fetch_err_nxt   = r_fetch_err;
      w_err_addr_nxt    = r_err_addr;

      case (r_state)
         S_IDLE: begin
            w_state_nxt    = S_FETCH;
            w_imem_req_nxt = 1'b1;
            w_cnt_nxt      = '0;
         end
         S_FETCH: begin
            // An ack in the final allowed cycle still wins over the timeout
            if (i_imem_ack) begin
               w_state_nxt       = S_HOLD;
               w_instr_nxt       = i_imem_rdata;
               w_instr_pc_nxt    = r_pc;
               w_instr_valid_nxt = 1'b1;
               w_imem_req_nxt    = 1'b0;
               w_cnt_nxt         = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt     = S_ERROR;
               w_fetch_err_nxt = 1'b1;
               w_err_addr_nxt  = r_pc;
               w_imem_req_nxt  = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (w_accept) begin
               w_instr_valid_nxt = 1'b0;
               if (w_target[1:0] != 2'b00) begin
                  w_state_nxt     = S_ERROR;
                  w_fetch_err_nxt = 1'b1;
                  w_err_addr_nxt  = w_target;
               end else begin
                  w_state_nxt    = S_FETCH;
                  w_pc_nxt       = w_target;
                  w_imem_req_nxt = 1'b1;
                  w_cnt_nxt      = '0;
               end
            end
         end
         S_ERROR: begin
            w_fetch_err_nxt   = 1'b1;
            w_imem_req_nxt    = 1'b0;
            w_instr_valid_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_imem_req    = r_imem_req;
   assign o_imem_addr   = r_pc;
   assign o_instr_valid = r_instr_valid;
   assign o_instr       = r_instr;
   assign o_opcode      = r_instr[6:0];
   assign o_instr_pc    = r_instr_pc;
   assign o_fetch_err   = r_fetch_err;
   assign o_err_addr    = r_err_addr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against a transaction-level PC model.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned TIMEOUT  = 16;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [31:0] instr_pc;
   logic        dec_ready = 1'b0;
   logic        branch = 1'b0;
   logic        zero = 1'b0;
   logic [31:0] branch_imm = 32'h0;
   logic        fetch_err;
   logic [31:0] err_addr;

   int n_checks = 0;
   int n_errors = 0;

   // Model: address of the next expected fetch and the instruction held for decode
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_instr_pc;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .o_imem_req   (imem_req),
      .o_imem_addr  (imem_addr),
      .i_imem_ack   (imem_ack),
      .i_imem_rdata (imem_rdata),
      .o_instr_valid(instr_valid),
      .o_instr      (instr),
      .o_opcode     (opcode),
      .o_instr_pc   (instr_pc),
      .i_dec_ready  (dec_ready),
      .i_branch     (branch),
      .i_zero       (zero),
      .i_branch_imm (branch_imm),
      .o_fetch_err  (fetch_err),
      .o_err_addr   (err_addr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b0; dec_ready = 1'b0; branch = 1'b0; zero = 1'b0;
      tick();
      tick();
      chk("rst_req",      {31'd0, imem_req},    32'd0);
      chk("rst_addr",     imem_addr,            RESET_PC);
      chk("rst_valid",    {31'd0, instr_valid}, 32'd0);
      chk("rst_instr",    instr,                NOP);
      chk("rst_opcode",   {25'd0, opcode},      32'h13);
      chk("rst_instr_pc", instr_pc,             32'd0);
      chk("rst_err",      {31'd0, fetch_err},   32'd0);
      chk("rst_err_addr", err_addr,             32'd0);
      rst = 1'b0;
      tick();
      m_pc = RESET_PC;
   endtask

   // Wait (bounded) for a request, let it stall `waits` cycles, then return `data`
   task automatic fetch(input int waits, input logic [31:0] data);
      int n = 0;
      while (imem_req !== 1'b1 && n < 4) begin
         tick();
         n++;
      end
      chk("req_seen",   {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr,         m_pc);
      for (int i = 0; i < waits; i++) begin
         tick();
         chk("req_stall", {31'd0, imem_req}, 32'd1);
      end
      imem_ack = 1'b1; imem_rdata = data;
      tick();
      imem_ack = 1'b0; imem_rdata = $urandom;
      m_instr = data; m_instr_pc = m_pc;
      chk("valid",    {31'd0, instr_valid}, 32'd1);
      chk("instr",    instr,                m_instr);
      chk("opcode",   {25'd0, opcode},      {25'd0, m_instr[6:0]});
      chk("instr_pc", instr_pc,             m_instr_pc);
      chk("req_drop", {31'd0, imem_req},    32'd0);
   endtask

   // Stall decode while memory strobes spuriously; held values must not move
   task automatic hold(input int n);
      for (int i = 0; i < n; i++) begin
         imem_ack = 1'($urandom % 2); imem_rdata = $urandom;
         dec_ready = 1'b0; branch = 1'($urandom % 2); zero = 1'($urandom % 2);
         tick();
         chk("hold_valid", {31'd0, instr_valid}, 32'd1);
         chk("hold_instr", instr,                m_instr);
         chk("hold_pc",    instr_pc,             m_instr_pc);
         chk("hold_req",   {31'd0, imem_req},    32'd0);
      end
      imem_ack = 1'b0; branch = 1'b0; zero = 1'b0;
   endtask

   task automatic accept(input logic br, input logic z, input logic [31:0] imm, output logic mis);
      logic [31:0] tgt;
      tgt = (br && z) ? (m_instr_pc + imm) : (m_instr_pc + 32'd4);
      mis = (tgt[1:0] != 2'b00);
      dec_ready = 1'b1; branch = br; zero = z; branch_imm = imm;
      imem_ack = 1'($urandom % 2);
      tick();
      dec_ready = 1'b0; branch = 1'b0; zero = 1'b0; imem_ack = 1'b0;
      chk("acc_valid", {31'd0, instr_valid}, 32'd0);
      if (mis) begin
         chk("mis_err",  {31'd0, fetch_err}, 32'd1);
         chk("mis_addr", err_addr,           tgt);
         chk("mis_req",  {31'd0, imem_req},  32'd0);
      end else begin
         chk("next_req",  {31'd0, imem_req},  32'd1);
         chk("next_addr", imem_addr,          tgt);
         chk("next_err",  {31'd0, fetch_err}, 32'd0);
         m_pc = tgt;
      end
   endtask

   // Error must be sticky regardless of inputs
   task automatic err_sticky(input logic [31:0] exp_addr);
      for (int i = 0; i < 3; i++) begin
         imem_ack = 1'($urandom % 2); dec_ready = 1'($urandom % 2);
         tick();
         chk("err_sticky", {31'd0, fetch_err},   32'd1);
         chk("err_hold",   err_addr,             exp_addr);
         chk("err_req",    {31'd0, imem_req},    32'd0);
         chk("err_valid",  {31'd0, instr_valid}, 32'd0);
      end
      imem_ack = 1'b0; dec_ready = 1'b0;
   endtask

   initial begin
      logic mis;
      logic [31:0] imm;
      logic br, z;

      m_pc = RESET_PC; m_instr = NOP; m_instr_pc = 32'h0;

      // Bring-up and first fetch with one wait cycle
      do_reset();
      fetch(1, 32'h0000_0093);

      // Sequential flow and taken/not-taken branches
      accept(1'b0, 1'b0, 32'h0, mis);           // -> 4
      fetch(0, 32'h0000_0013);
      accept(1'b0, 1'b1, 32'h40, mis);          // -> 8
      fetch(0, 32'h0040_0063);
      accept(1'b1, 1'b1, 32'hFFFF_FFF8, mis);   // 8-8 -> 0
      fetch(2, 32'h1234_5037);
      accept(1'b0, 1'b0, 32'h0, mis);           // -> 4
      fetch(0, 32'h0000_0013);
      accept(1'b0, 1'b0, 32'h0, mis);           // -> 8
      fetch(0, 32'h0000_0063);
      accept(1'b1, 1'b0, 32'hFFFF_FFF8, mis);   // not taken -> 12
      fetch(3, 32'hDEAD_BEEF);

      // Stalled decode with spurious acks, then zero-offset taken branch refetches 12
      hold(5);
      accept(1'b1, 1'b1, 32'h0, mis);
      chk("refetch_pc", m_pc, 32'd12);

      // Timeout at pc=12: 15 silent cycles stay in fetch, the 16th errors
      for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
         tick();
         chk("to_req", {31'd0, imem_req},  32'd1);
         chk("to_err", {31'd0, fetch_err}, 32'd0);
      end
      tick();
      chk("to_fire_err",  {31'd0, fetch_err}, 32'd1);
      chk("to_fire_addr", err_addr,           32'd12);
      chk("to_fire_req",  {31'd0, imem_req},  32'd0);
      err_sticky(32'd12);

      // Reset recovers and restarts at RESET_PC; exercise PC wrap-around
      do_reset();
      fetch(0, 32'h0000_0013);
      accept(1'b1, 1'b1, 32'hFFFF_FFFC, mis);   // 0-4 -> FFFF_FFFC
      fetch(0, 32'h0000_0033);
      accept(1'b0, 1'b0, 32'h0, mis);           // wraps to 0
      fetch(0, 32'h0000_0013);
      accept(1'b0, 1'b0, 32'h0, mis);           // -> 4
      fetch(1, 32'h0000_0063);

      // Misaligned branch target 4+6 = 10
      accept(1'b1, 1'b1, 32'd6, mis);
      chk("mis_flag", {31'd0, mis}, 32'd1);
      err_sticky(32'd10);

      // Reset in the same cycle as an ack discards the ack
      do_reset();
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_0003;
      tick();
      rst = 1'b0; imem_ack = 1'b0;
      chk("rack_valid", {31'd0, instr_valid}, 32'd0);
      chk("rack_instr", instr,                NOP);
      chk("rack_req",   {31'd0, imem_req},    32'd0);
      chk("rack_addr",  imem_addr,            RESET_PC);
      tick();
      m_pc = RESET_PC;
      fetch(0, 32'h0000_0013);

      // Randomized traffic against the PC model
      for (int t = 0; t < 40; t++) begin
         hold(int'($urandom_range(0, 3)));
         br  = 1'($urandom % 2);
         z   = 1'($urandom % 2);
         imm = (32'($urandom_range(0, 63)) << 2) - 32'd128;
         if ($urandom_range(0, 7) == 0) imm = imm | 32'd2;
         accept(br, z, imm, mis);
         if (mis) begin
            err_sticky((br && z) ? (m_instr_pc + imm) : (m_instr_pc + 32'd4));
            do_reset();
         end
         fetch(int'($urandom_range(0, 14)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
